// File: rtl/cmem_load_ctrl_pkg.sv
// cmem_load_ctrl_pkg: shared state encoding and sizing constants for the compensation-memory loader.
package cmem_load_ctrl_pkg;
    localparam int DEF_SIZE  = 8;
    localparam int DEF_SLOTS = 3;
    localparam int CW_W      = 3;
    localparam int CMEM_SIZE = DEF_SIZE * DEF_SLOTS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_SETTLE,
        S_READY,
        S_PRELOAD,
        S_FLUSH
    } state_e;
endpackage

// File: rtl/cmem_col_tracker.sv
// cmem_col_tracker: per-column slot/column counting, drop decision and change_col generation.
// ovf_err is only implemented when CMEM_LOAD_CTRL_OVF_CHECK_EN is defined.
module cmem_col_tracker
    import cmem_load_ctrl_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int SLOTS = DEF_SLOTS,
    parameter int COL_W = $clog2(SIZE)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic cw_valid,
    input  logic col_last,
    output logic accept,
    output logic change_col,
    output logic last_col,
    output logic ovf_err
);
    localparam int SW = $clog2(SLOTS + 1);

    logic [SW-1:0]    slot_cnt_q, slot_cnt_d, slot_post;
    logic [COL_W-1:0] col_cnt_q, col_cnt_d;

    // A full column already advanced the memory index, so it never strobes.
    always_comb begin
        accept     = en && cw_valid && slot_cnt_q < SW'(SLOTS);
        slot_post  = slot_cnt_q + SW'(accept);
        last_col   = en && col_last && col_cnt_q == COL_W'(SIZE - 1);
        change_col = en && col_last && slot_post < SW'(SLOTS) && !last_col;
        slot_cnt_d = (clr || (en && col_last)) ? '0 : slot_post;
        col_cnt_d  = clr ? '0 : (en && col_last && !last_col) ? col_cnt_q + 1'b1 : col_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
            col_cnt_q  <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            col_cnt_q  <= col_cnt_d;
        end
    end

`ifdef CMEM_LOAD_CTRL_OVF_CHECK_EN
    logic ovf_q, ovf_d;
    always_comb ovf_d = clr ? 1'b0 : (ovf_q | (en && cw_valid && !accept));
    always_ff @(posedge clk) ovf_q <= rst ? 1'b0 : ovf_d;
    assign ovf_err = ovf_q;
`else
    assign ovf_err = 1'b0;
`endif
endmodule

// File: rtl/cmem_load_ctrl.sv
// cmem_load_ctrl: forwards the compensation-weight stream into the memory and sequences its preload.
// Optional CMEM_LOAD_CTRL_OVF_CHECK_EN enables the sticky ovf_err flag.
module cmem_load_ctrl
    import cmem_load_ctrl_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int SLOTS = DEF_SLOTS,
    parameter int COL_W = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW_W-1:0] cw_in,
    input  logic            cw_in_valid,
    input  logic            col_last,
    input  logic            preload_req,
    output logic [CW_W-1:0] cmem_weight,
    output logic            cmem_wr,
    output logic            change_col,
    output logic            load_mem_done,
    output logic            preload_cw,
    output logic            busy,
    output logic            preload_done,
    output logic            ovf_err
);
    localparam int SW = $clog2(SLOTS + 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   beat_q, beat_d;
    logic [CW_W-1:0] cmem_weight_q, cmem_weight_d;
    logic            cmem_wr_q, cmem_wr_d;
    logic            change_col_q, change_col_d;
    logic            load_mem_done_q, load_mem_done_d;
    logic            preload_cw_q, preload_cw_d;
    logic            preload_done_q, preload_done_d;
    logic            clr, en, accept, chg, last_col;

    assign clr = state_q == S_IDLE && start;
    assign en  = state_q == S_LOAD;

    cmem_col_tracker #(.SIZE(SIZE), .SLOTS(SLOTS), .COL_W(COL_W)) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .en         (en),
        .cw_valid   (cw_in_valid),
        .col_last   (col_last),
        .accept     (accept),
        .change_col (chg),
        .last_col   (last_col),
        .ovf_err    (ovf_err)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE:    state_d = start ? S_LOAD : S_IDLE;
            S_LOAD:    state_d = last_col ? S_DRAIN : S_LOAD;
            S_DRAIN:   state_d = S_SETTLE;
            S_SETTLE:  state_d = S_READY;
            S_READY: begin
                state_d = preload_req ? S_PRELOAD : S_READY;
                beat_d  = '0;
            end
            S_PRELOAD: begin
                state_d = beat_q == SW'(SLOTS - 1) ? S_FLUSH : S_PRELOAD;
                beat_d  = beat_q + 1'b1;
            end
            default:   state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        cmem_wr_d       = accept;
        cmem_weight_d   = accept ? cw_in : '0;
        change_col_d    = chg;
        load_mem_done_d = state_d inside {S_SETTLE, S_READY, S_PRELOAD, S_FLUSH};
        preload_cw_d    = state_d == S_PRELOAD;
        preload_done_d  = state_d == S_FLUSH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            beat_q          <= '0;
            cmem_weight_q   <= '0;
            cmem_wr_q       <= 1'b0;
            change_col_q    <= 1'b0;
            load_mem_done_q <= 1'b0;
            preload_cw_q    <= 1'b0;
            preload_done_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            cmem_weight_q   <= cmem_weight_d;
            cmem_wr_q       <= cmem_wr_d;
            change_col_q    <= change_col_d;
            load_mem_done_q <= load_mem_done_d;
            preload_cw_q    <= preload_cw_d;
            preload_done_q  <= preload_done_d;
        end
    end

    assign cmem_weight   = cmem_weight_q;
    assign cmem_wr       = cmem_wr_q;
    assign change_col    = change_col_q;
    assign load_mem_done = load_mem_done_q;
    assign preload_cw    = preload_cw_q;
    assign preload_done  = preload_done_q;
    assign busy          = state_q != S_IDLE;
endmodule

// File: tb/tb_cmem_load_ctrl.sv
// tb_cmem_load_ctrl: randomized tile loads checked against a per-column reference model.
// Expected ovf_err follows CMEM_LOAD_CTRL_OVF_CHECK_EN.
module tb_cmem_load_ctrl;
    localparam int SIZE  = 8;
    localparam int SLOTS = 3;

    logic       clk = 1'b0;
    logic       rst, start, cw_in_valid, col_last, preload_req;
    logic [2:0] cw_in;
    logic [2:0] cmem_weight;
    logic       cmem_wr, change_col, load_mem_done, preload_cw, busy, preload_done, ovf_err;

    int         n_chk = 0;
    int         n_fail = 0;
    int         ncol[SIZE];
    bit         sep[SIZE];
    logic [2:0] act_w[$];
    int         n_chg;

    always #5 clk = ~clk;

    cmem_load_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cw_in         (cw_in),
        .cw_in_valid   (cw_in_valid),
        .col_last      (col_last),
        .preload_req   (preload_req),
        .cmem_weight   (cmem_weight),
        .cmem_wr       (cmem_wr),
        .change_col    (change_col),
        .load_mem_done (load_mem_done),
        .preload_cw    (preload_cw),
        .busy          (busy),
        .preload_done  (preload_done),
        .ovf_err       (ovf_err)
    );

    always @(negedge clk) begin
        if (cmem_wr) act_w.push_back(cmem_weight);
        if (change_col) n_chg++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr"}, cmem_wr, 0);
        chk({tag, "_w"}, cmem_weight, 0);
        chk({tag, "_chg"}, change_col, 0);
        chk({tag, "_lmd"}, load_mem_done, 0);
        chk({tag, "_pcw"}, preload_cw, 0);
        chk({tag, "_pdone"}, preload_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovf"}, ovf_err, 0);
    endtask

    task automatic run_tile(input int wait_cyc, input bit rst_mid);
        logic [2:0] exp_w[$];
        int         exp_chg = 0;
        bit         exp_ovf = 0;
        int         w;
        act_w.delete();
        n_chg = 0;
        start = 1;
        cyc();
        start = 0;
        chk("ovf_cleared", ovf_err, 0);
        chk("busy_load", busy, 1);
        for (int c = 0; c < SIZE; c++) begin
            for (int e = 0; e < ncol[c]; e++) begin
                while ($urandom_range(3) == 0) begin
                    cw_in_valid = 0;
                    col_last    = 0;
                    start       = $urandom_range(4) == 0;
                    cyc();
                end
                w           = $urandom_range(7);
                cw_in       = 3'(w);
                cw_in_valid = 1;
                col_last    = (e == ncol[c] - 1) && !sep[c];
                start       = $urandom_range(4) == 0;
                if (e < SLOTS) exp_w.push_back(3'(w));
                cyc();
            end
            if (ncol[c] == 0 || sep[c]) begin
                cw_in_valid = 0;
                col_last    = 1;
                start       = 0;
                cyc();
            end
            if (ncol[c] < SLOTS && c != SIZE - 1) exp_chg++;
`ifdef CMEM_LOAD_CTRL_OVF_CHECK_EN
            if (ncol[c] > SLOTS) exp_ovf = 1;
`endif
        end
        cw_in_valid = 0;
        col_last    = 0;
        start       = 0;
        chk("drain_busy", busy, 1);
        chk("drain_lmd", load_mem_done, 0);
        cyc();
        chk("settle_lmd", load_mem_done, 1);
        chk("settle_pcw", preload_cw, 0);
        cyc();
        for (int i = 0; i < wait_cyc; i++) begin
            chk("ready_lmd", load_mem_done, 1);
            chk("ready_pcw", preload_cw, 0);
            cw_in_valid = 1'($urandom_range(1));
            col_last    = 1'($urandom_range(1));
            cw_in       = 3'($urandom_range(7));
            start       = 1'($urandom_range(1));
            cyc();
        end
        cw_in_valid = 0;
        col_last    = 0;
        start       = 0;
        chk("wr_count", act_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < act_w.size(); i++)
            chk($sformatf("wr_data%0d", i), act_w[i], exp_w[i]);
        chk("chg_count", n_chg, exp_chg);
        chk("ovf", ovf_err, exp_ovf);
        preload_req = 1;
        cyc();
        chk("beat0_pcw", preload_cw, 1);
        preload_req = 1'($urandom_range(1));
        cyc();
        chk("beat1_pcw", preload_cw, 1);
        if (rst_mid) begin
            rst = 1;
            cyc();
            rst         = 0;
            preload_req = 0;
            chk_zero("rst_mid");
            return;
        end
        cyc();
        chk("beat2_pcw", preload_cw, 1);
        chk("beat2_pdone", preload_done, 0);
        cyc();
        chk("flush_pcw", preload_cw, 0);
        chk("flush_pdone", preload_done, 1);
        chk("flush_lmd", load_mem_done, 1);
        chk("flush_ovf", ovf_err, exp_ovf);
        preload_req = 0;
        cyc();
        chk("idle_busy", busy, 0);
        chk("idle_lmd", load_mem_done, 0);
        chk("idle_pdone", preload_done, 0);
        chk("idle_ovf", ovf_err, exp_ovf);
    endtask

    initial begin
        rst = 1;
        start = 0;
        cw_in = 0;
        cw_in_valid = 0;
        col_last = 0;
        preload_req = 0;
        cyc();
        cyc();
        rst = 0;
        chk_zero("reset");
        for (int c = 0; c < SIZE; c++) begin ncol[c] = 2; sep[c] = 0; end
        run_tile(10, 0);
        for (int c = 0; c < SIZE; c++) begin ncol[c] = 1; sep[c] = 0; end
        ncol[0] = 3; sep[0] = 1; ncol[1] = 0;
        run_tile(2, 0);
        ncol[3] = 4;
        run_tile(0, 0);
        for (int c = 0; c < SIZE; c++) begin ncol[c] = 2; sep[c] = 1; end
        run_tile(3, 1);
        for (int t = 0; t < 25; t++) begin
            for (int c = 0; c < SIZE; c++) begin
                ncol[c] = $urandom_range(4);
                sep[c]  = 1'($urandom_range(1));
            end
            run_tile($urandom_range(6), $urandom_range(5) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
